// File: rtl/videomem_axi_pkg.sv
// Shared types and helpers for the video-memory AXI responder.
package videomem_axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rd_state_t;

    // SRAM word-address width: byte-address width minus the byte-offset bits.
    function automatic int word_addr_w(input int size, input int dw);
        return size - $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/videomem_axi_rd_engine.sv
// Read side of the video-memory responder: AR acceptance, one SRAM read per
// beat (R_REQ), and a registered R channel. rd_port_req tells the top that
// the read side owns the SRAM port this cycle.
module videomem_axi_rd_engine import videomem_axi_pkg::*; #(
    parameter int DW  = 64,
    parameter int AW  = 18,
    parameter int WAW = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ARADDR,
    input  logic [7:0]      ARLEN,
    input  logic            ARVALID,
    output logic            ARREADY,
    output logic [DW-1:0]   RDATA,
    output logic            RLAST,
    output logic            RVALID,
    input  logic            RREADY,
    input  logic [DW-1:0]   mem_rdata,
    output logic            rd_port_req,
    output logic [WAW-1:0]  rd_addr
);

    rd_state_t       r_state;
    logic [8:0]      r_len, r_cnt;
    logic            arready_q, rvalid_q, rlast_q, rd_first;
    logic [DW-1:0]   rdata_q;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^ARADDR;

    assign ARREADY     = arready_q;
    assign RVALID      = rvalid_q;
    assign RLAST       = rlast_q;
    assign rd_port_req = (r_state == R_REQ);
    // SRAM data is only valid in the first R_DATA cycle; afterwards the
    // captured copy keeps RDATA stable while the initiator stalls.
    assign RDATA       = rd_first ? mem_rdata : rdata_q;

    // Read FSM: accept AR, issue one SRAM read, present the beat, repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= R_IDLE;
            rd_addr   <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rd_first  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && arready_q) begin
                        rd_addr   <= ARADDR[AW-1 -: WAW];
                        r_len     <= {1'b0, ARLEN};
                        r_cnt     <= '0;
                        arready_q <= 1'b0;
                        r_state   <= R_REQ;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_REQ: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= (r_cnt == r_len);
                    rd_first <= 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    rd_first <= 1'b0;
                    if (rd_first)
                        rdata_q <= mem_rdata;
                    if (RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= R_REQ;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/videomem_axi_slave.sv
// AXI4 responder for the video memory. Write FSM lives here; the read FSM is
// in videomem_axi_rd_engine. Reads take priority on the single SRAM port.
module videomem_axi_slave import videomem_axi_pkg::*; #(
    parameter int LOWRISC_AXI_DATA_WIDTH = 64,
    parameter int VIDEOMEM_SIZE          = 18,
    localparam int DW  = LOWRISC_AXI_DATA_WIDTH,
    localparam int WAW = word_addr_w(VIDEOMEM_SIZE, LOWRISC_AXI_DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VIDEOMEM_SIZE-1:0] AWADDR,
    input  logic [7:0]               AWLEN,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DW-1:0]            WDATA,
    input  logic [DW/8-1:0]          WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [VIDEOMEM_SIZE-1:0] ARADDR,
    input  logic [7:0]               ARLEN,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [DW-1:0]            RDATA,
    output logic [1:0]               RRESP,
    output logic                     RLAST,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [WAW-1:0]           mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic [DW/8-1:0]          mem_wstrb,
    input  logic [DW-1:0]            mem_rdata
);

    wr_state_t       w_state;
    logic [WAW-1:0]  w_addr;
    logic [8:0]      w_len, w_cnt;
    logic            w_err, awready_q, bvalid_q;
    resp_t           bresp_q;
    logic            w_hs, w_in_range;
    logic            rd_port_req;
    logic [WAW-1:0]  rd_addr;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^AWADDR;

    assign AWREADY    = awready_q;
    assign BVALID     = bvalid_q;
    assign BRESP      = bresp_q;
    assign RRESP      = RESP_OKAY;
    // A pending read request owns the port, so W is stalled for that cycle.
    assign WREADY     = (w_state == W_DATA) && !rd_port_req;
    assign w_hs       = WVALID && WREADY;
    assign w_in_range = (w_cnt <= w_len);
    assign mem_wdata  = WDATA;

    // Write FSM: AW latch, per-beat SRAM writes with overrun/underrun
    // tracking, then a B response held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && awready_q) begin
                        w_addr    <= AWADDR[VIDEOMEM_SIZE-1 -: WAW];
                        w_len     <= {1'b0, AWLEN};
                        w_cnt     <= '0;
                        w_err     <= 1'b0;
                        awready_q <= 1'b0;
                        w_state   <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (w_in_range) begin
                            w_addr <= w_addr + 1'b1;
                            w_cnt  <= w_cnt + 1'b1;
                        end else begin
                            w_err <= 1'b1;
                        end
                        if (WLAST) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= (w_err || !w_in_range || (w_cnt != w_len))
                                        ? RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // SRAM port mux: read request first, then an in-range write beat.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = w_addr;
        mem_wstrb = '0;
        if (rd_port_req) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (w_hs && w_in_range) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_wstrb = WSTRB;
        end
    end

    videomem_axi_rd_engine #(
        .DW  (DW),
        .AW  (VIDEOMEM_SIZE),
        .WAW (WAW)
    ) u_rd (
        .clk         (clk),
        .rst         (rst),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RLAST       (RLAST),
        .RVALID      (RVALID),
        .RREADY      (RREADY),
        .mem_rdata   (mem_rdata),
        .rd_port_req (rd_port_req),
        .rd_addr     (rd_addr)
    );

endmodule
